// File: rtl/aq_pmp_chk_pkg.sv
// Shared encodings for the MMU-to-PMP check sequencer: states, flag bit
// positions, access one-hot codes and the machine-mode privilege value.
package aq_pmp_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CHK0 = 2'd1,
    ST_CHK1 = 2'd2,
    ST_RESP = 2'd3
  } chk_state_e;

  localparam int FLG_L = 3;
  localparam int FLG_X = 2;
  localparam int FLG_W = 1;
  localparam int FLG_R = 0;

  localparam logic [2:0] ACC_R = 3'b001;
  localparam logic [2:0] ACC_W = 3'b010;
  localparam logic [2:0] ACC_X = 3'b100;

  localparam logic [1:0] PRIV_M = 2'b11;

endpackage

// File: rtl/aq_pmp_chk_deny.sv
// Per-phase permission decision from the winning entry's {L,X,W,R} flags.
module aq_pmp_chk_deny
  import aq_pmp_chk_pkg::*;
(
  input  logic [2:0] acc,
  input  logic [1:0] priv,
  input  logic [3:0] flg,
  output logic       deny
);

  // M-mode bypasses any unlocked entry; otherwise some requested access bit must be granted.
  assign deny = ~((priv == PRIV_M) & ~flg[FLG_L]) & ~|(acc & flg[FLG_X:FLG_R]);

endmodule

// File: rtl/aq_mmu_pmp_chk.sv
// Two-phase (page start / page end) PMP check sequencer between MMU and compare block.
// Optional one-entry result cache enabled by defining AQ_PMP_CHK_LAST_CACHE_EN.
module aq_mmu_pmp_chk
  import aq_pmp_chk_pkg::*;
#(
  parameter int HIT_W = 16,
  parameter int PA_W  = 28
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             mmu_pmpchk_req_vld,
  input  logic [PA_W-1:0]  mmu_pmpchk_req_pa,
  input  logic [1:0]       mmu_pmpchk_req_priv,
  input  logic [2:0]       mmu_pmpchk_req_acc,
  output logic             pmpchk_mmu_req_rdy,
  output logic             pmpchk_mmu_rsp_vld,
  output logic             pmpchk_mmu_rsp_fault,
  output logic             pmpchk_mmu_rsp_cross,
  output logic [HIT_W-1:0] pmpchk_mmu_rsp_hit,
  input  logic             mmu_pmpchk_rsp_rdy,
  output logic [PA_W-1:0]  mmu_pmp_pa,
  output logic [1:0]       mmu_pmp_priv_mode,
  output logic             mmu_pmp_chk1,
  input  logic [3:0]       pmp_mmu_flg,
  input  logic [HIT_W-1:0] pmp_mmu_hit_num,
  input  logic             pmp_mmu_napot_cross,
  input  logic             cp0_pmp_upd
);

  chk_state_e       state_q, state_d;
  logic [PA_W-1:0]  pa_q, pa_d;
  logic [1:0]       priv_q, priv_d;
  logic [2:0]       acc_q, acc_d;
  logic [3:0]       flg0_q, flg0_d;
  logic [HIT_W-1:0] hit0_q, hit0_d;
  logic             cross0_q, cross0_d;
  logic             fault_q, fault_d;
  logic             cross_q, cross_d;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic             deny0, deny1;

  aq_pmp_chk_deny u_deny0 (
    .acc  (acc_q),
    .priv (priv_q),
    .flg  (flg0_q),
    .deny (deny0)
  );

  // Phase 1 is judged on the live compare result while chk1 is driven.
  aq_pmp_chk_deny u_deny1 (
    .acc  (acc_q),
    .priv (priv_q),
    .flg  (pmp_mmu_flg),
    .deny (deny1)
  );

`ifdef AQ_PMP_CHK_LAST_CACHE_EN
  logic             cache_vld_q, cache_vld_d;
  logic [PA_W-1:0]  cache_pa_q, cache_pa_d;
  logic [1:0]       cache_priv_q, cache_priv_d;
  logic [2:0]       cache_acc_q, cache_acc_d;
  logic             cache_fault_q, cache_fault_d;
  logic             cache_cross_q, cache_cross_d;
  logic [HIT_W-1:0] cache_hit_q, cache_hit_d;
  logic             cache_match;

  assign cache_match = cache_vld_q & ~cp0_pmp_upd
                     & (mmu_pmpchk_req_pa == cache_pa_q)
                     & (mmu_pmpchk_req_priv == cache_priv_q)
                     & (mmu_pmpchk_req_acc == cache_acc_q);
`endif

  always_comb begin
    state_d  = state_q;
    pa_d     = pa_q;
    priv_d   = priv_q;
    acc_d    = acc_q;
    flg0_d   = flg0_q;
    hit0_d   = hit0_q;
    cross0_d = cross0_q;
    fault_d  = fault_q;
    cross_d  = cross_q;
    hit_d    = hit_q;
`ifdef AQ_PMP_CHK_LAST_CACHE_EN
    cache_vld_d   = cache_vld_q;
    cache_pa_d    = cache_pa_q;
    cache_priv_d  = cache_priv_q;
    cache_acc_d   = cache_acc_q;
    cache_fault_d = cache_fault_q;
    cache_cross_d = cache_cross_q;
    cache_hit_d   = cache_hit_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mmu_pmpchk_req_vld) begin
          pa_d    = mmu_pmpchk_req_pa;
          priv_d  = mmu_pmpchk_req_priv;
          acc_d   = mmu_pmpchk_req_acc;
          state_d = ST_CHK0;
`ifdef AQ_PMP_CHK_LAST_CACHE_EN
          if (cache_match) begin
            fault_d = cache_fault_q;
            cross_d = cache_cross_q;
            hit_d   = cache_hit_q;
            state_d = ST_RESP;
          end
`endif
        end
      end
      ST_CHK0: begin
        if (!cp0_pmp_upd) begin
          flg0_d   = pmp_mmu_flg;
          hit0_d   = pmp_mmu_hit_num;
          cross0_d = pmp_mmu_napot_cross;
          state_d  = ST_CHK1;
        end
      end
      ST_CHK1: begin
        // A PMP reprogram mid-check invalidates phase 0, so start over.
        if (cp0_pmp_upd) begin
          state_d = ST_CHK0;
        end else begin
          fault_d = deny0 | deny1 | cross0_q | pmp_mmu_napot_cross
                  | (hit0_q != pmp_mmu_hit_num);
          cross_d = cross0_q | pmp_mmu_napot_cross;
          hit_d   = hit0_q;
          state_d = ST_RESP;
`ifdef AQ_PMP_CHK_LAST_CACHE_EN
          cache_vld_d   = 1'b1;
          cache_pa_d    = pa_q;
          cache_priv_d  = priv_q;
          cache_acc_d   = acc_q;
          cache_fault_d = fault_d;
          cache_cross_d = cross_d;
          cache_hit_d   = hit_d;
`endif
        end
      end
      ST_RESP: begin
        if (mmu_pmpchk_rsp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef AQ_PMP_CHK_LAST_CACHE_EN
    if (cp0_pmp_upd) cache_vld_d = 1'b0;
`endif
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q  <= ST_IDLE;
      pa_q     <= '0;
      priv_q   <= '0;
      acc_q    <= '0;
      flg0_q   <= '0;
      hit0_q   <= '0;
      cross0_q <= 1'b0;
      fault_q  <= 1'b0;
      cross_q  <= 1'b0;
      hit_q    <= '0;
    end else begin
      state_q  <= state_d;
      pa_q     <= pa_d;
      priv_q   <= priv_d;
      acc_q    <= acc_d;
      flg0_q   <= flg0_d;
      hit0_q   <= hit0_d;
      cross0_q <= cross0_d;
      fault_q  <= fault_d;
      cross_q  <= cross_d;
      hit_q    <= hit_d;
    end
  end

`ifdef AQ_PMP_CHK_LAST_CACHE_EN
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      cache_vld_q   <= 1'b0;
      cache_pa_q    <= '0;
      cache_priv_q  <= '0;
      cache_acc_q   <= '0;
      cache_fault_q <= 1'b0;
      cache_cross_q <= 1'b0;
      cache_hit_q   <= '0;
    end else begin
      cache_vld_q   <= cache_vld_d;
      cache_pa_q    <= cache_pa_d;
      cache_priv_q  <= cache_priv_d;
      cache_acc_q   <= cache_acc_d;
      cache_fault_q <= cache_fault_d;
      cache_cross_q <= cache_cross_d;
      cache_hit_q   <= cache_hit_d;
    end
  end
`endif

  assign pmpchk_mmu_req_rdy   = (state_q == ST_IDLE);
  assign pmpchk_mmu_rsp_vld   = (state_q == ST_RESP);
  assign pmpchk_mmu_rsp_fault = fault_q;
  assign pmpchk_mmu_rsp_cross = cross_q;
  assign pmpchk_mmu_rsp_hit   = hit_q;
  assign mmu_pmp_pa           = pa_q;
  assign mmu_pmp_priv_mode    = priv_q;
  assign mmu_pmp_chk1         = (state_q == ST_CHK1);

endmodule

// File: tb/tb_aq_mmu_pmp_chk.sv
// Bench for aq_mmu_pmp_chk: directed requests, a transaction-level model checked
// every cycle, and literal expectations for latency and response fields.
module tb_aq_mmu_pmp_chk;
  import aq_pmp_chk_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic [27:0] req_pa = '0;
  logic [1:0]  req_priv = '0;
  logic [2:0]  req_acc = '0;
  logic        req_rdy;
  logic        rsp_vld, rsp_fault, rsp_cross;
  logic [15:0] rsp_hit;
  logic        rsp_rdy = 1'b0;
  logic [27:0] pmp_pa;
  logic [1:0]  pmp_priv;
  logic        pmp_chk1;
  logic [3:0]  pmp_flg;
  logic [15:0] pmp_hit;
  logic        pmp_cross;
  logic        upd = 1'b0;

  // The bench plays the compare block: phase-0 values unless chk1 is driven.
  logic [3:0]  ph_flg0 = '0, ph_flg1 = '0;
  logic [15:0] ph_hit0 = '0, ph_hit1 = '0;
  logic        ph_cross0 = 1'b0, ph_cross1 = 1'b0;
  assign pmp_flg   = pmp_chk1 ? ph_flg1 : ph_flg0;
  assign pmp_hit   = pmp_chk1 ? ph_hit1 : ph_hit0;
  assign pmp_cross = pmp_chk1 ? ph_cross1 : ph_cross0;

  int checks = 0;
  int failures = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  aq_mmu_pmp_chk dut (
    .forever_cpuclk       (clk),
    .cpurst               (rst),
    .mmu_pmpchk_req_vld   (req_vld),
    .mmu_pmpchk_req_pa    (req_pa),
    .mmu_pmpchk_req_priv  (req_priv),
    .mmu_pmpchk_req_acc   (req_acc),
    .pmpchk_mmu_req_rdy   (req_rdy),
    .pmpchk_mmu_rsp_vld   (rsp_vld),
    .pmpchk_mmu_rsp_fault (rsp_fault),
    .pmpchk_mmu_rsp_cross (rsp_cross),
    .pmpchk_mmu_rsp_hit   (rsp_hit),
    .mmu_pmpchk_rsp_rdy   (rsp_rdy),
    .mmu_pmp_pa           (pmp_pa),
    .mmu_pmp_priv_mode    (pmp_priv),
    .mmu_pmp_chk1         (pmp_chk1),
    .pmp_mmu_flg          (pmp_flg),
    .pmp_mmu_hit_num      (pmp_hit),
    .pmp_mmu_napot_cross  (pmp_cross),
    .cp0_pmp_upd          (upd)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit allowed(input logic [1:0] priv, input logic [2:0] acc, input logic [3:0] flg);
    if (priv == 2'b11 && !flg[3]) return 1'b1;
    return (acc & flg[2:0]) != 3'b000;
  endfunction

  // Transaction-level model: busy with a count of completed check cycles, or holding a response.
  bit          m_busy, m_resp, m_cvld;
  int          m_cnt;
  logic [27:0] m_pa, m_cpa;
  logic [1:0]  m_priv, m_cpriv;
  logic [2:0]  m_acc, m_cacc;
  logic [3:0]  m_flg0;
  logic [15:0] m_hit0, e_hit, m_chit;
  bit          m_cross0, e_fault, e_cross, m_cfault, m_ccross;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_resp = 0; m_cvld = 0; m_cnt = 0;
      m_pa = '0; m_priv = '0; m_acc = '0;
      e_fault = 0; e_cross = 0; e_hit = '0;
    end else begin
      if (m_resp) begin
        if (rsp_rdy) m_resp = 0;
      end else if (m_busy) begin
        if (upd) m_cnt = 0;
        else if (m_cnt == 0) begin
          m_flg0 = ph_flg0; m_hit0 = ph_hit0; m_cross0 = ph_cross0; m_cnt = 1;
        end else begin
          e_fault = !allowed(m_priv, m_acc, m_flg0) || !allowed(m_priv, m_acc, ph_flg1)
                    || m_cross0 || ph_cross1 || (m_hit0 != ph_hit1);
          e_cross = m_cross0 || ph_cross1;
          e_hit   = m_hit0;
          m_busy = 0; m_resp = 1;
          m_cvld = 1; m_cpa = m_pa; m_cpriv = m_priv; m_cacc = m_acc;
          m_cfault = e_fault; m_ccross = e_cross; m_chit = e_hit;
        end
      end else if (req_vld) begin
        m_pa = req_pa; m_priv = req_priv; m_acc = req_acc;
        m_busy = 1; m_cnt = 0;
`ifdef AQ_PMP_CHK_LAST_CACHE_EN
        if (m_cvld && !upd && req_pa == m_cpa && req_priv == m_cpriv && req_acc == m_cacc) begin
          m_busy = 0; m_resp = 1;
          e_fault = m_cfault; e_cross = m_ccross; e_hit = m_chit;
        end
`endif
      end
      if (upd) m_cvld = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && run_cmp) begin
      checkOutput("req_rdy", req_rdy, !(m_busy || m_resp));
      checkOutput("rsp_vld", rsp_vld, m_resp);
      checkOutput("chk1", pmp_chk1, m_busy && m_cnt == 1);
      if (m_busy) begin
        checkOutput("pmp_pa", pmp_pa, m_pa);
        checkOutput("pmp_priv", pmp_priv, m_priv);
      end
      if (m_resp) begin
        checkOutput("rsp_fault", rsp_fault, e_fault);
        checkOutput("rsp_cross", rsp_cross, e_cross);
        checkOutput("rsp_hit", rsp_hit, e_hit);
      end
    end
  end

  task automatic setPhases(input logic [3:0] f0, input logic [3:0] f1, input logic [15:0] h0,
                           input logic [15:0] h1, input logic c0, input logic c1);
    ph_flg0 = f0; ph_flg1 = f1; ph_hit0 = h0; ph_hit1 = h1; ph_cross0 = c0; ph_cross1 = c1;
  endtask

  task automatic pulseUpd();
    upd = 1'b1;
    @(posedge clk); #2;
    upd = 1'b0;
  endtask

  // Issues one request, scrambles the request bus while busy, waits for the response,
  // optionally stalls rsp_rdy (with an update pulse in RESP), then consumes it.
  task automatic applyStimulus(input logic [27:0] pa, input logic [1:0] priv, input logic [2:0] acc,
                               input int upd_at, input int hold, output int lat,
                               output logic f, output logic c, output logic [15:0] h);
    logic [31:0] r;
    req_vld = 1'b1; req_pa = pa; req_priv = priv; req_acc = acc;
    @(posedge clk); #2;
    r = $urandom; req_pa = r[27:0]; req_priv = r[29:28]; req_acc = r[2:0];
    lat = 1;
    while (!rsp_vld && lat < 20) begin
      upd = (lat == upd_at);
      @(posedge clk); #2;
      upd = 1'b0;
      lat++;
    end
    req_vld = 1'b0;
    checkOutput("rsp_wait", rsp_vld, 1'b1);
    f = rsp_fault; c = rsp_cross; h = rsp_hit;
    for (int i = 0; i < hold; i++) begin
      upd = (i == 0);
      @(posedge clk); #2;
      upd = 1'b0;
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #2;
    rsp_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    logic f, c;
    logic [15:0] h;

    #1;
    checkOutput("rst_rdy", req_rdy, 1'b1);
    checkOutput("rst_vld", rsp_vld, 1'b0);
    checkOutput("rst_fault", rsp_fault, 1'b0);
    checkOutput("rst_cross", rsp_cross, 1'b0);
    checkOutput("rst_hit", rsp_hit, 16'h0);
    checkOutput("rst_pa", pmp_pa, 28'h0);
    checkOutput("rst_priv", pmp_priv, 2'b00);
    checkOutput("rst_chk1", pmp_chk1, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    run_cmp = 1'b1;
    @(posedge clk); #2;

    setPhases(4'b0001, 4'b0001, 16'h0001, 16'h0001, 0, 0);
    applyStimulus(28'h0080000, 2'b00, ACC_R, -1, 0, lat, f, c, h);
    checkOutput("t1_lat", lat, 3);
    checkOutput("t1_fault", f, 1'b0);
    checkOutput("t1_hit", h, 16'h0001);

    setPhases(4'b0111, 4'b0111, 16'h0, 16'h0, 0, 0);
    applyStimulus(28'h0000100, 2'b11, ACC_W, -1, 0, lat, f, c, h);
    checkOutput("t2_m_default", f, 1'b0);
    setPhases(4'b0000, 4'b0000, 16'h0, 16'h0, 0, 0);
    applyStimulus(28'h0000100, 2'b01, ACC_W, -1, 0, lat, f, c, h);
    checkOutput("t2_s_nohit", f, 1'b1);

    setPhases(4'b1001, 4'b1001, 16'h0001, 16'h0001, 0, 0);
    applyStimulus(28'h0000200, 2'b11, ACC_X, -1, 0, lat, f, c, h);
    checkOutput("t3_locked", f, 1'b1);
    setPhases(4'b0001, 4'b0001, 16'h0001, 16'h0001, 0, 0);
    applyStimulus(28'h0000201, 2'b11, ACC_X, -1, 0, lat, f, c, h);
    checkOutput("t3_unlocked", f, 1'b0);

    setPhases(4'b0011, 4'b0011, 16'h0002, 16'h0004, 0, 0);
    applyStimulus(28'h0000300, 2'b00, ACC_R, -1, 0, lat, f, c, h);
    checkOutput("t4_hitdiff_fault", f, 1'b1);
    checkOutput("t4_hitdiff_cross", c, 1'b0);
    checkOutput("t4_hitdiff_hit", h, 16'h0002);
    setPhases(4'b0011, 4'b0011, 16'h0002, 16'h0002, 0, 1);
    applyStimulus(28'h0000301, 2'b00, ACC_R, -1, 0, lat, f, c, h);
    checkOutput("t4_cross_fault", f, 1'b1);
    checkOutput("t4_cross_cross", c, 1'b1);

    setPhases(4'b0001, 4'b0001, 16'h0001, 16'h0001, 0, 0);
    applyStimulus(28'h0000400, 2'b00, ACC_R, 2, 4, lat, f, c, h);
    checkOutput("t5_upd_lat", lat, 5);
    checkOutput("t5_upd_fault", f, 1'b0);

    setPhases(4'b0000, 4'b0000, 16'h0, 16'h0, 0, 0);
    applyStimulus(28'h0000500, 2'b11, 3'b000, -1, 0, lat, f, c, h);
    checkOutput("t6_acc0_m", f, 1'b0);
    setPhases(4'b0111, 4'b0111, 16'h0, 16'h0, 0, 0);
    applyStimulus(28'h0000501, 2'b00, 3'b000, -1, 0, lat, f, c, h);
    checkOutput("t6_acc0_u", f, 1'b1);
    setPhases(4'b0010, 4'b0010, 16'h0, 16'h0, 0, 0);
    applyStimulus(28'h0000502, 2'b00, 3'b011, -1, 0, lat, f, c, h);
    checkOutput("t6_acc_or", f, 1'b0);

    req_vld = 1'b1; req_pa = 28'h0000600; req_priv = 2'b00; req_acc = ACC_R;
    @(posedge clk); #2;
    req_vld = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_rdy", req_rdy, 1'b1);
    checkOutput("midrst_vld", rsp_vld, 1'b0);
    checkOutput("midrst_chk1", pmp_chk1, 1'b0);
    checkOutput("midrst_pa", pmp_pa, 28'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

`ifdef AQ_PMP_CHK_LAST_CACHE_EN
    setPhases(4'b0001, 4'b0001, 16'h0008, 16'h0008, 0, 0);
    applyStimulus(28'h0000700, 2'b00, ACC_R, -1, 0, lat, f, c, h);
    checkOutput("c1_lat", lat, 3);
    applyStimulus(28'h0000700, 2'b00, ACC_R, -1, 0, lat, f, c, h);
    checkOutput("c2_lat", lat, 1);
    checkOutput("c2_fault", f, 1'b0);
    checkOutput("c2_hit", h, 16'h0008);
    pulseUpd();
    applyStimulus(28'h0000700, 2'b00, ACC_R, -1, 0, lat, f, c, h);
    checkOutput("c3_lat", lat, 3);
`else
    setPhases(4'b0001, 4'b0001, 16'h0008, 16'h0008, 0, 0);
    applyStimulus(28'h0000700, 2'b00, ACC_R, -1, 0, lat, f, c, h);
    applyStimulus(28'h0000700, 2'b00, ACC_R, -1, 0, lat, f, c, h);
    checkOutput("nc_repeat_lat", lat, 3);
    pulseUpd();
`endif

    repeat (2) @(posedge clk);
    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
